// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - instruction fetch/execute sequencer for the 16-bit CPU core
// Optional single-step input enabled by defining SEQ_SINGLE_STEP_EN.
module cpu_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic        i_step,
`endif
    output logic        o_mem_req,
    output logic [15:0] o_mem_addr,
    input  logic [7:0]  i_mem_rdata,
    input  logic        i_mem_ack,
    output logic [15:0] o_inst,
    output logic [7:0]  o_data,
    output logic        o_dec_en,
    input  logic        i_inst_branch,
    input  logic        i_if_zero,
    input  logic        i_if_not_zero,
    input  logic        i_if_else,
    input  logic        i_if_not_else,
    input  logic [15:0] i_rhs,
    input  logic        i_acc_zero,
    output logic [15:0] o_pc,
    output logic        o_else_flag,
    output logic        o_busy,
    output logic        o_fault
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_HI, S_FETCH_LO, S_FETCH_DATA, S_EXEC, S_FAULT
    } state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_t      r_state;
    logic [15:0] r_pc, r_start_pc, r_inst, r_mem_addr;
    logic [7:0]  r_data;
    logic        r_mem_req, r_dec_en, r_else_flag, r_skip, r_fault;
    logic [31:0] r_wait;

    logic        w_start, w_continue, w_timeout, w_any_flag, w_cond, w_data_inst;
    logic [15:0] w_pc_inc, w_pc_exec;

`ifdef SEQ_SINGLE_STEP_EN
    logic r_step_mode;
    assign w_start    = i_run | i_step;
    assign w_continue = i_run & ~r_step_mode;
`else
    assign w_start    = i_run;
    assign w_continue = i_run;
`endif

    assign w_pc_inc    = r_pc + 16'd1;
    assign w_data_inst = (r_inst[15:14] == 2'b10) && (r_inst[10:9] == 2'b01);
    assign w_any_flag  = i_if_zero | i_if_not_zero | i_if_else | i_if_not_else;
    // No condition flag set means "always true", which also covers non-IF instructions.
    assign w_cond      = ~w_any_flag
                       | (i_if_zero & i_acc_zero) | (i_if_not_zero & ~i_acc_zero)
                       | (i_if_else & r_else_flag) | (i_if_not_else & ~r_else_flag);
    assign w_pc_exec   = (!r_skip && i_inst_branch) ? (r_start_pc + i_rhs) : r_pc;
    assign w_timeout   = (TIMEOUT > 0) && r_mem_req && !i_mem_ack && (r_wait == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_start_pc  <= RESET_PC;
            r_inst      <= 16'h0000;
            r_data      <= 8'h00;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= RESET_PC;
            r_dec_en    <= 1'b0;
            r_else_flag <= 1'b0;
            r_skip      <= 1'b0;
            r_fault     <= 1'b0;
            r_wait      <= 32'd0;
`ifdef SEQ_SINGLE_STEP_EN
            r_step_mode <= 1'b0;
`endif
        end else begin
            r_dec_en <= 1'b0;
            if (r_mem_req && !i_mem_ack)
                r_wait <= r_wait + 32'd1;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state    <= S_FETCH_HI;
                        r_start_pc <= r_pc;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pc;
                        r_wait     <= 32'd0;
`ifdef SEQ_SINGLE_STEP_EN
                        r_step_mode <= ~i_run;
`endif
                    end
                end
                S_FETCH_HI, S_FETCH_LO, S_FETCH_DATA: begin
                    if (w_timeout) begin
                        r_state   <= S_FAULT;
                        r_mem_req <= 1'b0;
                        r_fault   <= 1'b1;
                    end else if (i_mem_ack) begin
                        r_pc       <= w_pc_inc;
                        r_mem_addr <= w_pc_inc;
                        r_wait     <= 32'd0;
                        if (r_state == S_FETCH_HI) begin
                            r_inst[15:8] <= i_mem_rdata;
                            r_state      <= S_FETCH_LO;
                        end else if (r_state == S_FETCH_LO && w_data_inst) begin
                            r_inst[7:0] <= i_mem_rdata;
                            r_state     <= S_FETCH_DATA;
                        end else begin
                            if (r_state == S_FETCH_LO)
                                r_inst[7:0] <= i_mem_rdata;
                            else
                                r_data <= i_mem_rdata;
                            r_state   <= S_EXEC;
                            r_mem_req <= 1'b0;
                            r_dec_en  <= ~r_skip;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_skip) begin
                        r_skip <= 1'b0;
                    end else begin
                        r_skip <= ~w_cond;
                        if (i_if_zero | i_if_not_zero)
                            r_else_flag <= ~w_cond;
                    end
                    r_pc       <= w_pc_exec;
                    r_mem_addr <= w_pc_exec;
                    if (w_continue) begin
                        r_state    <= S_FETCH_HI;
                        r_start_pc <= w_pc_exec;
                        r_mem_req  <= 1'b1;
                        r_wait     <= 32'd0;
                    end else begin
                        r_state <= S_IDLE;
                    end
`ifdef SEQ_SINGLE_STEP_EN
                    r_step_mode <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_addr  = r_mem_addr;
    assign o_inst      = r_inst;
    assign o_data      = r_data;
    assign o_dec_en    = r_dec_en;
    assign o_pc        = r_pc;
    assign o_else_flag = r_else_flag;
    assign o_busy      = (r_state != S_IDLE) && (r_state != S_FAULT);
    assign o_fault     = r_fault;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer
module tb_cpu_sequencer;
    logic        clk = 1'b0;
    logic        rst, run, mem_req, mem_ack, dec_en, acc_zero, ack_en, chk_addr;
    logic        inst_branch, if_zero, if_not_zero, if_else, if_not_else;
    logic        else_flag, busy, fault;
    logic [15:0] mem_addr, inst, rhs, pc;
    logic [7:0]  mem_rdata, data;
    logic [7:0]  mem [0:65535];

    typedef struct packed {
        logic [15:0] inst;
        logic [7:0]  data;
        logic        dec_en;
        logic [15:0] pc;
        logic        else_flag;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] addr_q[$];
    int          n_vec = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.RESET_PC(16'h0100), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .i_run(run),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
        .o_inst(inst), .o_data(data), .o_dec_en(dec_en),
        .i_inst_branch(inst_branch), .i_if_zero(if_zero), .i_if_not_zero(if_not_zero),
        .i_if_else(if_else), .i_if_not_else(if_not_else), .i_rhs(rhs), .i_acc_zero(acc_zero),
        .o_pc(pc), .o_else_flag(else_flag), .o_busy(busy), .o_fault(fault)
    );

    // Zero-wait memory and a toy decoder: Exxx = branch by sext(xxx), Fx?x = IF with code in [7:4].
    assign mem_rdata   = mem[mem_addr];
    assign mem_ack     = mem_req & ack_en;
    assign inst_branch = (inst[15:12] == 4'hE);
    assign rhs         = {{4{inst[11]}}, inst[11:0]};
    assign if_zero     = (inst[15:12] == 4'hF) && (inst[7:4] == 4'h0);
    assign if_else     = (inst[15:12] == 4'hF) && (inst[7:4] == 4'h1);
    assign if_not_zero = (inst[15:12] == 4'hF) && (inst[7:4] == 4'h2);
    assign if_not_else = (inst[15:12] == 4'hF) && (inst[7:4] == 4'h3);

    always @(negedge clk) begin
        if (!rst && busy && !mem_req) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL exec_unexpected: got inst=%h pc=%h, required none", inst, pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({inst, data, dec_en, pc, else_flag} !== e) begin
                    n_miss++;
                    $display("FAIL exec: got inst=%h data=%h dec_en=%b pc=%h else=%b, required inst=%h data=%h dec_en=%b pc=%h else=%b",
                             inst, data, dec_en, pc, else_flag, e.inst, e.data, e.dec_en, e.pc, e.else_flag);
                end
            end
        end
        if (!rst && chk_addr && mem_req && mem_ack) begin
            n_vec++;
            if (addr_q.size() == 0) begin
                n_miss++;
                $display("FAIL fetch_unexpected: got addr=%h, required none", mem_addr);
            end else begin
                logic [15:0] a;
                a = addr_q.pop_front();
                if (mem_addr !== a) begin
                    n_miss++;
                    $display("FAIL fetch_addr: got %h, required %h", mem_addr, a);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [15:0] i, input logic [7:0] d, input logic de,
                            input logic [15:0] p, input logic ef);
        exp_t e;
        e.inst = i; e.data = d; e.dec_en = de; e.pc = p; e.else_flag = ef;
        exp_q.push_back(e);
    endtask

    logic [23:0] prog [23];
    bit done;

    initial begin
        rst = 1'b1; run = 1'b0; ack_en = 1'b1; acc_zero = 1'b0; chk_addr = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        prog = '{24'h010088, 24'h010105, 24'h01028A, 24'h010300, 24'h01047F,
                 24'h0105F0, 24'h010600, 24'h010788, 24'h010811, 24'h0109F0,
                 24'h010A10, 24'h010B88, 24'h010C22, 24'h010DEF, 24'h010E03,
                 24'h0010EF, 24'h0011F0, 24'h0000EF, 24'h0001FE, 24'hFFFEE0,
                 24'hFFFF04, 24'h000288, 24'h000333};
        for (int i = 0; i < 23; i++) begin
            mem[prog[i][23:8]] = prog[i][7:0];
            addr_q.push_back(prog[i][23:8]);
        end
        repeat (2) @(negedge clk);
        check("rst_mem_req", {15'd0, mem_req}, 16'h0000);
        check("rst_mem_addr", mem_addr, 16'h0100);
        check("rst_pc", pc, 16'h0100);
        check("rst_inst", inst, 16'h0000);
        check("rst_data", {8'h00, data}, 16'h0000);
        check("rst_dec_en", {15'd0, dec_en}, 16'h0000);
        check("rst_else", {15'd0, else_flag}, 16'h0000);
        check("rst_busy", {15'd0, busy}, 16'h0000);
        check("rst_fault", {15'd0, fault}, 16'h0000);

        push_exp(16'h8805, 8'h00, 1'b1, 16'h0102, 1'b0);
        push_exp(16'h8A00, 8'h7F, 1'b1, 16'h0105, 1'b0);
        push_exp(16'hF000, 8'h7F, 1'b1, 16'h0107, 1'b0);
        push_exp(16'h8811, 8'h7F, 1'b0, 16'h0109, 1'b1);
        push_exp(16'hF010, 8'h7F, 1'b1, 16'h010B, 1'b1);
        push_exp(16'h8822, 8'h7F, 1'b1, 16'h010D, 1'b1);
        push_exp(16'hEF03, 8'h7F, 1'b1, 16'h010F, 1'b1);
        push_exp(16'hEFF0, 8'h7F, 1'b1, 16'h0012, 1'b1);
        push_exp(16'hEFFE, 8'h7F, 1'b1, 16'h0002, 1'b1);
        push_exp(16'hE004, 8'h7F, 1'b1, 16'h0000, 1'b1);
        push_exp(16'h8833, 8'h7F, 1'b1, 16'h0004, 1'b1);

        rst = 1'b0; run = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 && addr_q.size() == 0) begin
                run = 1'b0;
                done = 1'b1;
            end
        end
        n_vec++;
        if (!done) begin
            n_miss++;
            $display("FAIL program_timeout: got %0d pending, required 0", exp_q.size() + addr_q.size());
            run = 1'b0;
        end
        @(negedge clk);
        check("stop_busy", {15'd0, busy}, 16'h0000);
        check("stop_pc", pc, 16'h0004);
        check("stop_mem_req", {15'd0, mem_req}, 16'h0000);

        // Reset in the middle of FETCH_LO
        chk_addr = 1'b0;
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lo_mem_req", {15'd0, mem_req}, 16'h0001);
        check("lo_inst_hi", inst, 16'h8800);
        #1 rst = 1'b1;
        #1;
        check("arst_mem_req", {15'd0, mem_req}, 16'h0000);
        check("arst_pc", pc, 16'h0100);
        check("arst_inst", inst, 16'h0000);
        check("arst_mem_addr", mem_addr, 16'h0100);

        // Bus timeout
        ack_en = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("to_req_start", {15'd0, mem_req}, 16'h0001);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("to_no_fault_yet", {15'd0, fault}, 16'h0000);
        end
        @(negedge clk);
        check("to_fault", {15'd0, fault}, 16'h0001);
        check("to_mem_req", {15'd0, mem_req}, 16'h0000);
        check("to_busy", {15'd0, busy}, 16'h0000);
        ack_en = 1'b1;
        repeat (10) @(negedge clk);
        check("to_sticky", {15'd0, fault}, 16'h0001);
        check("to_sticky_req", {15'd0, mem_req}, 16'h0000);
        run = 1'b0;
        #1 rst = 1'b1;
        #1 check("to_cleared", {15'd0, fault}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Instruction fetch/execute sequencer for the 16-bit CPU core. It fetches each instruction over the 8-bit memory port as two bytes, high byte first, plus an optional trailing data byte. It presents the assembled word and data byte to the instruction decoder and pulses the decoder enable for exactly one execute cycle. It also owns the PC, branch target update, conditional-skip logic for the IF instructions, and a bus-timeout fault.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
TIMEOUT, 0, max cycles mem_req may wait for mem_ack; 0 disables the timeout

Ports:
clk  input  1  core clock
rst  input  1  asynchronous reset, active-high
run  input  1  level; high = keep executing, low = stop in IDLE after the current instruction
mem_req  output  1  byte read request
mem_addr  output  16  byte address; stable while mem_req is high
mem_rdata  input  8  read data, valid in the mem_ack cycle
mem_ack  input  1  transfer completes on a rising edge where mem_req and mem_ack are both high
inst  output  16  registered instruction word to the decoder
data  output  8  registered data byte to the decoder
dec_en  output  1  decoder enable, high only in EXEC of a non-skipped instruction
inst_branch  input  1  decoder flag
if_zero, if_not_zero, if_else, if_not_else  input  1 each  decoder IF flags
rhs  input  16  decoder rhs; signed branch offset when inst_branch
acc_zero  input  1  accumulator == 0, from the datapath
pc  output  16  address of the next instruction to fetch
else_flag  output  1  result of the last IF-zero test, inverted
busy  output  1  high in every state except IDLE and FAULT
fault  output  1  sticky bus-timeout fault

Behaviour:
- Reset values: state IDLE, pc = RESET_PC, inst = 0, data = 0, mem_req = 0, mem_addr = RESET_PC, dec_en = 0, else_flag = 0, skip = 0, fault = 0.
- Reset asserted mid-transfer abandons the transfer immediately; mem_req drops asynchronously.

State machine:
- States: IDLE, FETCH_HI, FETCH_LO, FETCH_DATA, EXEC, FAULT.
- IDLE: if run is high, go to FETCH_HI; start_pc <= pc.
- FETCH_HI: mem_req = 1, mem_addr = pc. On ack: inst[15:8] <= mem_rdata, pc <= pc + 1, go to FETCH_LO.
- FETCH_LO: same handshake. On ack: inst[7:0] <= mem_rdata, pc <= pc + 1.
  - Data-bearing instruction (inst[15:14] == 2'b10 and inst[10:9] == 2'b01): go to FETCH_DATA.
  - Otherwise: go to EXEC.
- FETCH_DATA: same handshake. On ack: data <= mem_rdata, pc <= pc + 1, go to EXEC.
- Only one byte transfers per ack edge. mem_req may remain high across consecutive bytes; mem_addr advances on the same edge as the ack.
- PC arithmetic is modulo 2^16. Fetch wraps from 16'hFFFF to 16'h0000 without error.

EXEC (exactly 1 cycle):
- If skip = 1: dec_en = 0, skip <= 0, no branch/IF evaluation. Otherwise dec_en = 1.
- inst_branch: pc <= start_pc + rhs (mod 2^16).
- IF, with cond = (if_zero & acc_zero) | (if_not_zero & ~acc_zero) | (if_else & else_flag) | (if_not_else & ~else_flag):
  - skip <= ~cond.
  - if_zero / if_not_zero also set else_flag <= ~cond. if_else / if_not_else leave else_flag unchanged.
- IF with none of the four flags set (undefined condition code): treated as cond = 1.
- Leave EXEC: go to FETCH_HI if run is high (start_pc <= pc_next), else go to IDLE.

Boundary conditions and timing:
- run dropping mid-fetch does not abort; the instruction completes, then the block enters IDLE.
- Skip survives an IDLE stop and applies to the next instruction executed.
- Minimum latency per instruction with zero-wait ack: 3 cycles (4 with a data byte).
- Timeout (TIMEOUT > 0): a counter resets on each ack or state entry and increments while mem_req is high without ack. When it reaches TIMEOUT: go to FAULT, mem_req = 0, fault = 1.
- FAULT is left only by reset.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN adds input step (1 bit).
- With it: in IDLE, a step pulse while run is low executes exactly one instruction, then the block returns to IDLE. step is ignored in all other states and when run is high.
- Without it: no step port; only run starts execution.

Test Plan:
- Reset with RESET_PC = 16'h0100, then run = 1, zero-wait memory holding 0x88,0x05 (add imm) at 0x0100 -> mem_addr 0x0100, 0x0101; inst = 16'h8805; dec_en high for 1 cycle in cycle 3; pc = 16'h0102.
- Memory 0x8A,0x00,0x7F (add with data byte) -> FETCH_DATA entered; data = 8'h7F; dec_en pulses once; pc advances by 3.
- Branch at 0x0010 with rhs = 16'hFFF0 -> next fetch address 16'h0000. Branch at 0xFFFE with rhs = 16'h0004 -> next fetch address 16'h0002 (wrap).
- IF-zero (16'hF000) with acc_zero = 0 -> else_flag = 1; the next instruction is fetched but executes with dec_en = 0. Then IF-else (16'hF010) -> cond true, no skip.
- TIMEOUT = 4 with mem_ack held low -> fault = 1 and mem_req = 0 after 4 wait cycles; the block stays in FAULT until rst.
- Assert rst during FETCH_LO -> mem_req drops immediately; pc = RESET_PC; inst = 0.
